window_scan_ctrl: RTL and testbench
===================================

// Module: window_scan_ctrl
// PURPOSE
// - Raster-scans a 128x128 frame and sequences the 3x3 window fetch/sum unit once per pixel.
// - Per pixel: drives the window start address, pulses start, waits for finish and captures the 8-bit sum.
// - Writes the sum, or a binarised value, to the result memory over a valid/ready handshake.
// - Sits between the top-level frame control and the window unit / result RAM.
// PARAMETERS
// - IMG_W    128  frame width in pixels (power of 2; column field = log2(IMG_W) bits)
// - IMG_H    128  frame height in pixels (power of 2; row field = log2(IMG_H) bits)
// - ADDR_W   14   pixel address width, {row,col}
// - TMO      15   max cycles in WAIT before win_finish is declared missing
// PORTS
// - clk        in   1       clock, rising edge
// - rst        in   1       synchronous, active-high reset
// - go         in   1       start-of-frame request; sampled in IDLE only
// - busy       out  1       high from the cycle after go is accepted until DONE
// - done       out  1       one-cycle pulse in DONE
// - err        out  1       sticky timeout flag; cleared by rst or by the next accepted go
// - win_start  out  1       one-cycle pulse to window unit (ISSUE state)
// - win_addr   out  ADDR_W  {row,col} of window centre; constant from ISSUE through WAIT
// - win_finish in   1       window unit done; win_sum valid in the same cycle
// - win_sum    in   8       window sum (modulo 256)
// - res_valid  out  1       result write request
// - res_ready  in   1       result sink accepts when res_valid && res_ready
// - res_addr   out  ADDR_W  result address, equal to win_addr of the same pixel
// - res_data   out  8       result value
// - thr        in   8       binarisation threshold (present only with WSC_THRESH_EN)
// BEHAVIOUR
// - Reset: state=IDLE, row=col=0; busy, done, err, win_start, res_valid = 0; win_addr, res_addr, res_data = 0.
// - FSM states and transitions:
//   - IDLE -> ISSUE on go; clears err and row/col.
//   - ISSUE: win_start=1 for exactly one cycle -> WAIT.
//   - WAIT: counts cycles. On win_finish, register win_sum into res_data -> WRITE.
//     If the count reaches TMO first: set err, res_data=0 -> WRITE.
//   - WRITE: res_valid=1, res_addr/res_data held stable until res_ready. On the handshake -> ADV.
//   - ADV: col+1; when col wraps IMG_W-1->0, row+1. Pixel (IMG_H-1,IMG_W-1) done -> DONE, else -> ISSUE.
//   - DONE: done=1 for one cycle -> IDLE.
// - Timing: the window unit asserts finish 10 cycles after win_start. With res_ready=1, one pixel
//   takes 13 cycles (ISSUE 1 + WAIT 10 + WRITE 1 + ADV 1). A full frame is 16384*13 = 212992 cycles.
// - win_addr changes only in ADV. This guarantees at least 2 cycles between finish and the next start.
// - Boundary conditions:
//   - go while busy is ignored.
//   - win_finish outside WAIT is ignored.
//   - go and done in the same cycle: go is not accepted until the FSM is back in IDLE.
//   - res_ready may stall WRITE indefinitely; the timeout counter is inactive outside WAIT.
//   - rst mid-frame aborts immediately to the reset values; no further writes are issued.
//   - Row/col counters use log2 widths and never exceed IMG_H-1 / IMG_W-1.
// CONFIGURATION
// - Macro WSC_THRESH_EN:
//   - Defined: port thr exists; res_data = (win_sum >= thr) ? 8'd255 : 8'd0. A timeout still yields 0.
//   - Undefined: no thr port; res_data = win_sum unchanged.
// STRUCTURE
// - Package wsc_pkg: state encoding constants (IDLE..DONE, 3 bits), IMG_W, IMG_H, ADDR_W, TMO defaults.
// - Sub-module wsc_raster_cnt: row/col counter with clr, inc, last_pix output; instantiated once.
// - FSM, timeout counter and result register live in window_scan_ctrl.
// TESTING
// 1. rst, then go=1 for 1 cycle with a model window unit (finish at +10), res_ready=1
//    -> first win_addr=0x0000, win_start pulses every 13 cycles, done at cycle 212992+1, 16384 writes.
// 2. Model returns sum=8'hA5 at pixel (5,127) -> res_addr=0x02FF, res_data=0xA5; next win_addr=0x0300.
// 3. res_ready held low 20 cycles in WRITE -> res_valid/res_addr/res_data stable for all 20 cycles,
//    exactly one write on release.
// 4. Model never asserts finish for pixel 3 -> err=1 after 15 WAIT cycles, res_data=0, scan continues;
//    the next go clears err.
// 5. rst asserted mid-frame at pixel 100 -> next cycle busy=0, res_valid=0, win_addr=0;
//    go while busy has no effect.
// 6. WSC_THRESH_EN, thr=128: sums 127/128/255 -> res_data 0/255/255.

Source files
------------

// File: rtl/wsc_pkg.sv
// Shared constants and state encoding for the window scan controller.
// Optional WSC_THRESH_EN build binarises results against a threshold port.
package wsc_pkg;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int ADDR_W = 14;
    localparam int TMO    = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_ADV   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/window_scan_ctrl_if.sv
// Window-unit and result-sink signals of the scan controller.
// Master is the controller; slave is the window unit plus result RAM.
interface window_scan_ctrl_if #(
    parameter int AW = wsc_pkg::ADDR_W
) ();

    logic          win_start;
    logic [AW-1:0] win_addr;
    logic          win_finish;
    logic [7:0]    win_sum;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_addr;
    logic [7:0]    res_data;

    modport master (
        output win_start, win_addr,
        input  win_finish, win_sum,
        output res_valid, res_addr, res_data,
        input  res_ready
    );

    modport slave (
        input  win_start, win_addr,
        output win_finish, win_sum,
        input  res_valid, res_addr, res_data,
        output res_ready
    );

endinterface

// File: rtl/wsc_raster_cnt.sv
// Row/col raster counter; col wraps into a row increment.
// last_pix flags the bottom-right pixel of the frame.
module wsc_raster_cnt #(
    parameter int W  = 128,
    parameter int H  = 128,
    parameter int CW = $clog2(W),
    parameter int RW = $clog2(H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last_pix
);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          col_last;

    assign col_last = (col_q == CW'(W - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            col_d = col_q + 1'b1;
            if (col_last) begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row      = row_q;
    assign col      = col_q;
    assign last_pix = col_last && (row_q == RW'(H - 1));

endmodule

// File: rtl/window_scan_ctrl.sv
// Raster-scan sequencer for the 3x3 window unit and result writes.
// WSC_THRESH_EN adds port thr and writes 255/0 instead of the raw sum.
module window_scan_ctrl
    import wsc_pkg::*;
#(
    parameter int IMG_W  = wsc_pkg::IMG_W,
    parameter int IMG_H  = wsc_pkg::IMG_H,
    parameter int ADDR_W = wsc_pkg::ADDR_W,
    parameter int TMO    = wsc_pkg::TMO
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic busy,
    output logic done,
    output logic err,
`ifdef WSC_THRESH_EN
    input  logic [7:0] thr,
`endif
    window_scan_ctrl_if.master bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int TW = $clog2(TMO + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [7:0]    data_q, data_d;
    logic          clr, inc, last_pix;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [7:0]    res_val;

    wsc_raster_cnt #(
        .W (IMG_W),
        .H (IMG_H)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .inc      (inc),
        .row      (row),
        .col      (col),
        .last_pix (last_pix)
    );

`ifdef WSC_THRESH_EN
    assign res_val = (bus.win_sum >= thr) ? 8'hFF : 8'h00;
`else
    assign res_val = bus.win_sum;
`endif

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        data_d  = data_q;
        clr     = 1'b0;
        inc     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_ISSUE;
                    err_d   = 1'b0;
                    clr     = 1'b1;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // finish wins over a timeout landing in the same cycle
                if (bus.win_finish) begin
                    data_d  = res_val;
                    state_d = S_WRITE;
                end else if (tmo_q == TW'(TMO - 1)) begin
                    err_d   = 1'b1;
                    data_d  = 8'h00;
                    state_d = S_WRITE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (bus.res_ready) begin
                    state_d = S_ADV;
                end
            end
            S_ADV: begin
                inc     = 1'b1;
                state_d = last_pix ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign bus.win_start = (state_q == S_ISSUE);
    assign bus.win_addr  = ADDR_W'({row, col});
    assign bus.res_valid = (state_q == S_WRITE);
    assign bus.res_addr  = ADDR_W'({row, col});
    assign bus.res_data  = data_q;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl on a 128x8 frame.
// Model window unit answers 10 cycles after start.
module tb_window_scan_ctrl;
    import wsc_pkg::*;

    localparam int W    = 128;
    localparam int H    = 8;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go  = 1'b0;
    logic busy, done, err;
    logic m_fin = 1'b0;
    logic spur  = 1'b0;
    logic rdy   = 1'b1;
    logic [7:0] m_sum = 8'h00;
`ifdef WSC_THRESH_EN
    logic [7:0] thr = 8'd128;
`endif

    window_scan_ctrl_if #(.AW(14)) bus ();

    assign bus.win_finish = m_fin | spur;
    assign bus.win_sum    = spur ? 8'h11 : m_sum;
    assign bus.res_ready  = rdy;

    window_scan_ctrl #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .busy (busy),
        .done (done),
        .err  (err),
`ifdef WSC_THRESH_EN
        .thr  (thr),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int         pix;
        logic [7:0] sum;
        logic [7:0] exp_raw;
        logic [7:0] exp_thr;
    } vec_t;

    vec_t tbl[5];

    function automatic logic [7:0] sum_of(input int a);
        logic [7:0] s;
        s = 8'(a * 7 + 3);
        for (int i = 0; i < 5; i++)
            if (tbl[i].pix == a) s = tbl[i].sum;
        return s;
    endfunction

    function automatic logic [7:0] exp_of(input logic [7:0] s);
`ifdef WSC_THRESH_EN
        return (s >= 8'd128) ? 8'hFF : 8'h00;
`else
        return s;
`endif
    endfunction

    // model window unit
    int         cd = 0;
    int         drop_pix = -1;
    logic [13:0] m_addr = '0;

    always @(negedge clk) begin
        m_fin = 1'b0;
        if (rst) begin
            cd = 0;
        end else if (bus.win_start) begin
            m_addr = bus.win_addr;
            cd = 10;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0 && int'(m_addr) != drop_pix) begin
                m_fin = 1'b1;
                m_sum = sum_of(int'(m_addr));
            end
        end
    end

    // result sink monitor
    int         cyc = 0;
    int         wr_cnt = 0;
    int         bad_addr = 0;
    int         wr_per[NPIX];
    logic [7:0] cap[NPIX];

    always @(posedge clk) begin
        cyc++;
        if (!rst && bus.res_valid && bus.res_ready) begin
            wr_cnt++;
            if (int'(bus.res_addr) < NPIX) begin
                wr_per[int'(bus.res_addr)]++;
                cap[int'(bus.res_addr)] = bus.res_data;
            end else begin
                bad_addr++;
            end
        end
    end

    // start spacing monitor
    logic        chk_seq = 1'b0;
    logic        first = 1'b1;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          seq_bad = 0;
    logic [13:0] first_addr = '0;
    logic [13:0] last_addr = '0;

    always @(negedge clk) begin
        if (chk_seq && bus.win_start) begin
            if (first) begin
                first_addr = bus.win_addr;
                first_cyc  = cyc;
                first      = 1'b0;
            end else begin
                if (cyc - last_cyc != 13 || bus.win_addr != last_addr + 14'd1)
                    seq_bad++;
                if (last_addr == 14'h2FF)
                    check("addr_after_2ff", 32'(bus.win_addr), 32'h300);
            end
            last_cyc  = cyc;
            last_addr = bus.win_addr;
        end
    end

    task automatic clear_sb();
        wr_cnt   = 0;
        bad_addr = 0;
        for (int i = 0; i < NPIX; i++) begin
            wr_per[i] = 0;
            cap[i]    = 8'h00;
        end
    endtask

    task automatic frame_data(input string nm);
        int bad_cnt;
        int bad_dat;
        logic [7:0] e;
        bad_cnt = bad_addr;
        bad_dat = 0;
        for (int a = 0; a < NPIX; a++) begin
            if (wr_per[a] != 1) bad_cnt++;
            e = (a == drop_pix) ? 8'h00 : exp_of(sum_of(a));
            if (cap[a] !== e) bad_dat++;
        end
        check({nm, "_one_write_each"}, 32'(bad_cnt), 0);
        check({nm, "_data_all"}, 32'(bad_dat), 0);
    endtask

    // kind 0: start at addr a, 1: write request at a, 2: done
    task automatic wait_for(input int kind, input int a, input string nm);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 20000 && !hit; i++) begin
            @(negedge clk);
            case (kind)
                0: hit = bus.win_start && int'(bus.win_addr) == a;
                1: hit = bus.res_valid && int'(bus.res_addr) == a;
                default: hit = done;
            endcase
        end
        if (!hit) check({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    int c0, ts, sbad;
    logic [13:0] h_addr;
    logic [7:0]  h_data;

    initial begin
        tbl[0] = '{pix: 32'h2FF, sum: 8'hA5, exp_raw: 8'hA5, exp_thr: 8'hFF};
        tbl[1] = '{pix: 32'h010, sum: 8'd127, exp_raw: 8'd127, exp_thr: 8'h00};
        tbl[2] = '{pix: 32'h011, sum: 8'd128, exp_raw: 8'd128, exp_thr: 8'hFF};
        tbl[3] = '{pix: 32'h012, sum: 8'd255, exp_raw: 8'd255, exp_thr: 8'hFF};
        tbl[4] = '{pix: 32'h013, sum: 8'd0, exp_raw: 8'd0, exp_thr: 8'h00};
        clear_sb();

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_win_start", 32'(bus.win_start), 0);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_win_addr", 32'(bus.win_addr), 0);
        check("rst_res_addr", 32'(bus.res_addr), 0);
        check("rst_res_data", 32'(bus.res_data), 0);
        rst = 1'b0;
        @(negedge clk);

        // frame A: nominal timing
        clear_sb();
        chk_seq = 1'b1;
        first   = 1'b1;
        pulse_go();
        c0 = cyc;
        check("a_busy_after_go", 32'(busy), 1);
        wait_for(2, 0, "a_done");
        check("a_done_cycle", 32'(cyc - c0), 32'd13312);
        check("a_first_addr", 32'(first_addr), 0);
        check("a_first_start", 32'(first_cyc - c0), 0);
        check("a_start_seq", 32'(seq_bad), 0);
        check("a_writes", 32'(wr_cnt), NPIX);
        check("a_err", 32'(err), 0);
        frame_data("a");
        for (int i = 0; i < 5; i++) begin
`ifdef WSC_THRESH_EN
            check($sformatf("vec%0d_data", i), 32'(cap[tbl[i].pix]),
                  32'(tbl[i].exp_thr));
`else
            check($sformatf("vec%0d_data", i), 32'(cap[tbl[i].pix]),
                  32'(tbl[i].exp_raw));
`endif
        end
        chk_seq = 1'b0;

        // go during DONE must not start a new frame
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("go_in_done_busy", 32'(busy), 0);
        check("go_in_done_pulse", 32'(done), 0);
        @(negedge clk);
        check("go_in_done_idle", 32'(busy), 0);

        // frame B: timeout at pixel 3, stall at pixel 7
        clear_sb();
        drop_pix = 3;
        pulse_go();
        wait_for(0, 3, "b_start3");
        ts = cyc;
        check("b_err_before", 32'(err), 0);
        wait_for(1, 3, "b_write3");
        check("b_tmo_latency", 32'(cyc - ts), 16);
        check("b_tmo_err", 32'(err), 1);
        check("b_tmo_data", 32'(bus.res_data), 0);
        wait_for(1, 7, "b_write7");
        rdy    = 1'b0;
        h_addr = bus.res_addr;
        h_data = bus.res_data;
        sbad   = 0;
        for (int i = 0; i < 20; i++) begin
            spur = (i == 5);
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || bus.res_addr !== h_addr ||
                bus.res_data !== h_data)
                sbad++;
        end
        spur = 1'b0;
        check("b_stall_stable", 32'(sbad), 0);
        check("b_stall_no_write", 32'(wr_per[7]), 0);
        rdy = 1'b1;
        @(negedge clk);
        check("b_release_write", 32'(wr_per[7]), 1);
        wait_for(2, 0, "b_done");
        check("b_err_sticky", 32'(err), 1);
        check("b_writes", 32'(wr_cnt), NPIX);
        frame_data("b");
        drop_pix = -1;
        @(negedge clk);

        // frame C: go clears err, go while busy ignored, rst aborts
        clear_sb();
        pulse_go();
        check("c_err_cleared", 32'(err), 0);
        wait_for(0, 50, "c_start50");
        pulse_go();
        check("c_go_busy_busy", 32'(busy), 1);
        check("c_go_busy_addr", 32'(bus.win_addr), 50);
        wait_for(0, 100, "c_start100");
        rst = 1'b1;
        @(negedge clk);
        check("c_rst_busy", 32'(busy), 0);
        check("c_rst_valid", 32'(bus.res_valid), 0);
        check("c_rst_addr", 32'(bus.win_addr), 0);
        rst  = 1'b0;
        sbad = 0;
        ts   = wr_cnt;
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.win_start !== 1'b0)
                sbad++;
        end
        check("c_abort_quiet", 32'(sbad), 0);
        check("c_abort_writes", 32'(ts), 100);
        check("c_no_more_writes", 32'(wr_cnt), 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
